ram_arbiter: RTL and testbench

Two-requester arbiter that shares one single-port synchronous block RAM between the CPU instruction-fetch port and the CPU data port. It replaces the dual-port RAM hookup in the SoC top, performing byte-lane alignment for sub-word data accesses and round-robin arbitration when both ports request in the same cycle. It sits between `minaret`'s `imem_*`/`dmem_*` buses and a single-port RAM macro with one-cycle read latency.

---
 rtl/ram_arbiter.sv | 145 ++++++++++++++
 tb/tb_ram_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - single-port RAM arbiter for instruction-fetch and data ports
//
// Shares one single-port synchronous RAM (one-cycle read latency) between the
// CPU fetch port (imem_*) and data port (dmem_*). Sub-word data accesses are
// lane-aligned on the way in and right-justified on the way out. Simultaneous
// requests are resolved round-robin.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   imem_valid/ready    fetch handshake (ready is a one-cycle completion pulse)
//   imem_addr/rdata     fetch byte address, fetched word
//   dmem_valid/ready    data handshake (ready is a one-cycle completion pulse)
//   dmem_addr           data byte address ([1:0] is the byte offset)
//   dmem_wmask/wdata    LSB-aligned byte enables (0 = read) and write data
//   dmem_rdata          read word shifted down by the byte offset
//   ram_en/addr         RAM access strobe and word address
//   ram_wmask/wdata     lane-aligned RAM byte enables and write data
//   ram_rdata           RAM read data, valid the cycle after ram_en

module ram_arbiter #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  imem_valid,
    output logic                  imem_ready,
    input  logic [31:0]           imem_addr,
    output logic [31:0]           imem_rdata,

    input  logic                  dmem_valid,
    output logic                  dmem_ready,
    input  logic [31:0]           dmem_addr,
    input  logic [3:0]            dmem_wmask,
    input  logic [31:0]           dmem_wdata,
    output logic [31:0]           dmem_rdata,

    output logic                  ram_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [3:0]            ram_wmask,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_I = 2'd1,
        RESP_D = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    // 0 = fetch port preferred on contention, 1 = data port preferred.
    logic        r_prio;
    // Byte offset of the data access in flight, used to right-justify its read data.
    logic [1:0]  r_offset;

    logic        w_grant_i;
    logic        w_grant_d;
    logic [1:0]  w_doff;
    logic [3:0]  w_dmask_aligned;
    logic [31:0] w_dwdata_aligned;

    // Address bits outside the RAM window are intentionally ignored (aliasing).
    logic        w_unused_addr_bits;
    assign w_unused_addr_bits = ^{imem_addr[31:ADDR_WIDTH+2], imem_addr[1:0],
                                  dmem_addr[31:ADDR_WIDTH+2]};

    assign w_doff = dmem_addr[1:0];

    // Lanes shifted above byte 3 fall off the top rather than wrapping around.
    assign w_dmask_aligned  = dmem_wmask << w_doff;
    assign w_dwdata_aligned = dmem_wdata << {w_doff, 3'b000};

    // Grants only happen in IDLE. Reset gates them so the RAM strobe stays low
    // while reset is held even if requests are already pending.
    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (r_state == IDLE && !reset) begin
            w_grant_d = dmem_valid && (!imem_valid || r_prio);
            w_grant_i = imem_valid && !w_grant_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_prio   <= 1'b1;
            r_offset <= 2'd0;
        end else begin
            r_state <= w_next_state;
            // After every grant the other port gets preference next time.
            if (w_grant_i) begin
                r_prio <= 1'b1;
            end else if (w_grant_d) begin
                r_prio   <= 1'b0;
                r_offset <= w_doff;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        imem_ready   = 1'b0;
        dmem_ready   = 1'b0;
        ram_en       = 1'b0;
        ram_addr     = '0;
        ram_wmask    = 4'h0;
        ram_wdata    = 32'h0;

        case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    ram_en       = 1'b1;
                    ram_addr     = dmem_addr[ADDR_WIDTH+1:2];
                    ram_wmask    = w_dmask_aligned;
                    ram_wdata    = w_dwdata_aligned;
                    w_next_state = RESP_D;
                end else if (w_grant_i) begin
                    ram_en       = 1'b1;
                    ram_addr     = imem_addr[ADDR_WIDTH+1:2];
                    w_next_state = RESP_I;
                end
            end
            // Requests seen during a response cycle are left for the next IDLE.
            RESP_I: begin
                imem_ready   = 1'b1;
                w_next_state = IDLE;
            end
            RESP_D: begin
                dmem_ready   = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign imem_rdata = ram_rdata;
    assign dmem_rdata = ram_rdata >> {r_offset, 3'b000};

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - scoreboard testbench for ram_arbiter

module tb_ram_arbiter;

    localparam int AW    = 14;
    localparam int WORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          imem_valid;
    logic          imem_ready;
    logic [31:0]   imem_addr;
    logic [31:0]   imem_rdata;
    logic          dmem_valid;
    logic          dmem_ready;
    logic [31:0]   dmem_addr;
    logic [3:0]    dmem_wmask;
    logic [31:0]   dmem_wdata;
    logic [31:0]   dmem_rdata;
    logic          ram_en;
    logic [AW-1:0] ram_addr;
    logic [3:0]    ram_wmask;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_valid (imem_valid),
        .imem_ready (imem_ready),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .dmem_valid (dmem_valid),
        .dmem_ready (dmem_ready),
        .dmem_addr  (dmem_addr),
        .dmem_wmask (dmem_wmask),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .ram_en     (ram_en),
        .ram_addr   (ram_addr),
        .ram_wmask  (ram_wmask),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    // Behavioural single-port RAM with one-cycle read latency.
    logic [31:0] mem [WORDS];
    always @(posedge clk) begin
        if (ram_en) begin
            for (int j = 0; j < 4; j++)
                if (ram_wmask[j]) mem[ram_addr][8*j +: 8] <= ram_wdata[8*j +: 8];
            ram_rdata <= mem[ram_addr];
        end
    end

    // Shadow of RAM contents as the bench expects them to be.
    logic [31:0] exp_mem [WORDS];

    typedef struct {
        logic        wr;
        logic [31:0] data;
    } dexp_t;

    logic [31:0] iq [$];
    dexp_t       dq [$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic model_write(input int word, input int off, input logic [3:0] m,
                               input logic [31:0] d);
        for (int j = 0; j < 4; j++)
            if (m[j] && (off + j) < 4) exp_mem[word][8*(off+j) +: 8] = d[8*j +: 8];
    endtask

    // Response monitor: pops the scoreboard on every ready pulse.
    logic prev_i = 1'b0;
    logic prev_d = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            if (imem_ready && dmem_ready) check_eq("both_ready", 32'd1, 32'd0);
            if (imem_ready || dmem_ready) check_eq("ram_en_in_resp", {31'd0, ram_en}, 32'd0);
            if (imem_ready) begin
                check_eq("i_pulse_len", {31'd0, prev_i}, 32'd0);
                if (iq.size() == 0) check_eq("i_unexpected", 32'd1, 32'd0);
                else check_eq("i_rdata", imem_rdata, iq.pop_front());
            end
            if (dmem_ready) begin
                dexp_t e;
                check_eq("d_pulse_len", {31'd0, prev_d}, 32'd0);
                if (dq.size() == 0) check_eq("d_unexpected", 32'd1, 32'd0);
                else begin
                    e = dq.pop_front();
                    if (!e.wr) check_eq("d_rdata", dmem_rdata, e.data);
                end
            end
        end
        prev_i = imem_ready && !reset;
        prev_d = dmem_ready && !reset;
    end

    task automatic imem_fetch(input logic [31:0] a);
        int w;
        w = int'(a[AW+1:2]);
        @(posedge clk); #1;
        imem_addr  = a;
        imem_valid = 1'b1;
        iq.push_back(exp_mem[w]);
        @(negedge clk);
        check_eq("i_grant_en", {31'd0, ram_en}, 32'd1);
        check_eq("i_grant_addr", {18'd0, ram_addr}, w);
        check_eq("i_grant_wmask", {28'd0, ram_wmask}, 32'd0);
        @(negedge clk);
        check_eq("i_latency", {31'd0, imem_ready}, 32'd1);
        check_eq("i_no_dready", {31'd0, dmem_ready}, 32'd0);
        @(posedge clk); #1;
        imem_valid = 1'b0;
    endtask

    task automatic dmem_access(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d,
                               input int exp_word, input logic [3:0] exp_wm,
                               input logic [31:0] exp_wd);
        dexp_t e;
        int    off;
        off = int'(a[1:0]);
        @(posedge clk); #1;
        dmem_addr  = a;
        dmem_wmask = m;
        dmem_wdata = d;
        dmem_valid = 1'b1;
        e.wr = (m != 4'h0);
        if (e.wr) begin
            model_write(exp_word, off, m, d);
            e.data = 32'h0;
        end else begin
            e.data = exp_mem[exp_word] >> (8 * off);
        end
        dq.push_back(e);
        @(negedge clk);
        check_eq("d_grant_en", {31'd0, ram_en}, 32'd1);
        check_eq("d_grant_addr", {18'd0, ram_addr}, exp_word);
        check_eq("d_grant_wmask", {28'd0, ram_wmask}, {28'd0, exp_wm});
        if (m != 4'h0) check_eq("d_grant_wdata", ram_wdata, exp_wd);
        @(negedge clk);
        check_eq("d_latency", {31'd0, dmem_ready}, 32'd1);
        check_eq("d_no_iready", {31'd0, imem_ready}, 32'd0);
        @(posedge clk); #1;
        dmem_valid = 1'b0;
        dmem_wmask = 4'h0;
    endtask

    // Both ports request from reset release for n cycles; reset must be high on entry.
    task automatic contend(input int n);
        imem_addr  = 32'h0000_0010;
        dmem_addr  = 32'h0000_0021;
        dmem_wmask = 4'h0;
        imem_valid = 1'b1;
        dmem_valid = 1'b1;
        for (int k = 0; k < n / 4; k++) begin
            dexp_t e;
            e.wr   = 1'b0;
            e.data = exp_mem[8] >> 8;
            dq.push_back(e);
            iq.push_back(exp_mem[4]);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k == 0) check_eq("first_grant_d", {18'd0, ram_addr}, 32'd8);
            check_eq("pat_i", {31'd0, imem_ready}, {31'd0, (k % 4) == 3});
            check_eq("pat_d", {31'd0, dmem_ready}, {31'd0, (k % 4) == 1});
        end
        @(posedge clk); #1;
        imem_valid = 1'b0;
        dmem_valid = 1'b0;
    endtask

    initial begin
        int pulses;
        for (int i = 0; i < WORDS; i++) begin
            mem[i]     = 32'h5A00_0000 ^ (i * 32'h0001_0203);
            exp_mem[i] = 32'h5A00_0000 ^ (i * 32'h0001_0203);
        end
        mem[4]     = 32'hDEAD_BEEF;
        exp_mem[4] = 32'hDEAD_BEEF;
        ram_rdata  = 32'h0;

        reset      = 1'b1;
        imem_valid = 1'b0;
        imem_addr  = 32'h0;
        dmem_valid = 1'b0;
        dmem_addr  = 32'h0;
        dmem_wmask = 4'h0;
        dmem_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_iready", {31'd0, imem_ready}, 32'd0);
        check_eq("rst_dready", {31'd0, dmem_ready}, 32'd0);
        check_eq("rst_ram_en", {31'd0, ram_en}, 32'd0);
        check_eq("rst_wmask", {28'd0, ram_wmask}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        imem_fetch(32'h0000_0010);
        imem_fetch(32'hFFFF_0010);

        dmem_access(32'h0000_0023, 4'h1, 32'h0000_00AB, 8, 4'h8, 32'hAB00_0000);
        dmem_access(32'h0000_0023, 4'h0, 32'h0,         8, 4'h0, 32'h0);
        dmem_access(32'h0000_0003, 4'h3, 32'h0000_1234, 0, 4'h8, 32'h3400_0000);
        dmem_access(32'h0000_0000, 4'h0, 32'h0,         0, 4'h0, 32'h0);
        dmem_access(32'h0000_0032, 4'h3, 32'h0000_BEEF, 12, 4'hC, 32'hBEEF_0000);
        dmem_access(32'h0000_0031, 4'h0, 32'h0,         12, 4'h0, 32'h0);
        dmem_access(32'h0000_0032, 4'h0, 32'h0,         12, 4'h0, 32'h0);
        dmem_access(32'h0000_0041, 4'hF, 32'hCAFE_F00D, 16, 4'hE, 32'hFEF0_0D00);
        dmem_access(32'h0000_0040, 4'h0, 32'h0,         16, 4'h0, 32'h0);

        // Back-to-back fetches only.
        pulses = 0;
        @(posedge clk); #1;
        imem_addr  = 32'h0000_0014;
        imem_valid = 1'b1;
        for (int k = 0; k < 3; k++) iq.push_back(exp_mem[5]);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (imem_ready) pulses++;
        end
        @(posedge clk); #1;
        imem_valid = 1'b0;
        check_eq("b2b_pulses", pulses, 32'd3);

        // Continuous contention from reset.
        reset = 1'b1;
        #1;
        contend(8);

        // Reset while a data response is being presented.
        @(posedge clk); #1;
        dmem_addr  = 32'h0000_0022;
        dmem_wmask = 4'h0;
        dmem_valid = 1'b1;
        @(negedge clk);
        check_eq("rd_grant_en", {31'd0, ram_en}, 32'd1);
        @(posedge clk); #1;
        check_eq("rd_resp_pre", {31'd0, dmem_ready}, 32'd1);
        reset = 1'b1;
        #1;
        check_eq("rd_resp_drop", {31'd0, dmem_ready}, 32'd0);
        check_eq("rd_ram_en_rst", {31'd0, ram_en}, 32'd0);
        contend(4);

        repeat (2) @(posedge clk);
        check_eq("iq_empty", iq.size(), 32'd0);
        check_eq("dq_empty", dq.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
